board_btn_debounce: RTL and testbench
=====================================

Name: board_btn_debounce

Overview:
Input-side conditioning for the board's push buttons. The display path drives LEDs and the 7-segment outputs toward the user; this block handles the opposite direction. It takes raw, bouncing, asynchronous push-button levels and delivers clean, synchronised levels plus single-cycle press and release strobes. Downstream stages (register read, ALU flag latch, write-back) step on these strobes instead of on raw button edges.

Parameters:
- N_BTN, 3, number of independent button channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised cycles required to accept a level change (10 ms at 100 MHz). Legal range is at least 2. Simulation uses 4.
- CNT_W, 20, debounce counter width. Must satisfy 2**CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk, input, 1, system clock. Every flop is clocked on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- btn_raw, input, N_BTN, raw button levels, asynchronous to clk. 1 = pressed.
- btn_level, output, N_BTN, debounced level per channel, registered.
- btn_press, output, N_BTN, one-cycle strobe on an accepted 0->1 change, registered.
- btn_release, output, N_BTN, one-cycle strobe on an accepted 1->0 change, registered.

Behaviour:
- Reset (rst_n=0, asynchronous): sync flops = 0, counters = 0, every channel in IDLE, btn_level = btn_press = btn_release = 0. Deassertion is taken on the next clk edge with no other special handling.
- Synchroniser: two flops per channel (s1, s2). The FSM sees only s2.
- Per-channel FSM, all channels fully independent:
  - IDLE (level 0): s2=1 -> WAIT_HI, cnt<=0. Otherwise stay.
  - WAIT_HI: s2=0 -> IDLE, cnt<=0, no strobe (bounce rejected). s2=1 and cnt==DEBOUNCE_CYCLES-1 -> HIGH, btn_level<=1, btn_press<=1. Otherwise cnt<=cnt+1.
  - HIGH (level 1): s2=0 -> WAIT_LO, cnt<=0. Otherwise stay.
  - WAIT_LO: s2=1 -> HIGH, cnt<=0, no strobe. s2=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, btn_level<=0, btn_release<=1. Otherwise cnt<=cnt+1.
- Strobes are high for exactly one cycle. A strobe register is cleared on every edge where it is not being set.
- Latency: let edge 0 be the first clk edge that samples btn_raw=1 and the input stay high. Then btn_press and btn_level rise after edge DEBOUNCE_CYCLES+2. Release is symmetric.
- A held button gives exactly one btn_press, no matter how long it is held.
- Any 0-sample inside WAIT_HI restarts qualification from IDLE. The counter never wraps, because it only counts up to DEBOUNCE_CYCLES-1.
- btn_press and btn_release never assert together on a channel.
- Several channels may strobe in the same cycle.
- Reset during WAIT_HI or WAIT_LO abandons qualification: no strobe, and the level returns to 0.

Decomposition:
- Shared package board_io_pkg:
  - FSM state encoding: 2-bit localparams ST_IDLE, ST_WAIT_HI, ST_HIGH, ST_WAIT_LO.
  - Default debounce constant.
- Sub-module btn_debounce_ch: one channel containing synchroniser, counter and FSM, with ports clk, rst_n, raw, level, press, release.
- Top level generate-instantiates N_BTN copies of btn_debounce_ch.

Test Plan (DEBOUNCE_CYCLES=4, N_BTN=3):
1. Clean press: btn_raw[0] goes 0->1 and is held 20 cycles -> btn_press[0]=1 for exactly one cycle after edge 6, and btn_level[0]=1 from then on. Other channels stay 0.
2. Bounce rejection: btn_raw[1] pattern 1,1,0,1,1,0 (one cycle each), then 0 -> btn_press[1] and btn_level[1] stay 0 throughout.
3. Release: continue from scenario 1, drop btn_raw[0] to 0 -> btn_release[0] pulses once after edge 6 (relative to the first 0 sample), btn_level[0]=0, and btn_press[0] does not fire.
4. Long hold: btn_raw[2]=1 held for 100 cycles -> exactly one btn_press[2] pulse, and btn_level[2] stays 1.
5. Simultaneous channels: btn_raw = 3'b111 on the same edge -> all three press bits pulse in the same cycle.
6. Reset mid-qualification: assert rst_n=0 asynchronously 2 cycles into WAIT_HI on channel 0 -> outputs go to 0 immediately. After release with btn_raw still high, the press pulse arrives a full DEBOUNCE_CYCLES+2 edges later.

Source files
------------

// File: rtl/board_io_pkg.sv
// Shared definitions for the board input path: per-channel debounce FSM
// encoding and default debounce timing.
package board_io_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_HI = 2'd1;
    localparam logic [1:0] ST_HIGH    = 2'd2;
    localparam logic [1:0] ST_WAIT_LO = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_WAIT_HI = ST_WAIT_HI,
        S_HIGH    = ST_HIGH,
        S_WAIT_LO = ST_WAIT_LO
    } ch_state_e;

    // 10 ms at 100 MHz; the counter width must hold DEBOUNCE_DEFAULT-1.
    localparam int DEBOUNCE_DEFAULT = 1000000;
    localparam int CNT_W_DEFAULT    = 20;

endpackage

// File: rtl/btn_debounce_ch.sv
// One push-button channel: two-flop synchroniser, qualification counter and
// FSM producing a clean level plus one-cycle press/release strobes.
module btn_debounce_ch
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rls
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rls_q, rls_d;

    always_comb begin
        s1_d    = raw;
        s2_d    = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rls_d   = 1'b0;

        // Only s2 is safe to use; s1 may still be resolving metastability.
        case (state_q)
            S_IDLE: begin
                if (s2_q) begin
                    state_d = S_WAIT_HI;
                    cnt_d   = '0;
                end
            end
            S_WAIT_HI: begin
                if (!s2_q) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (!s2_q) begin
                    state_d = S_WAIT_LO;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LO: begin
                if (s2_q) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    level_d = 1'b0;
                    rls_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rls_q   <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rls_q   <= rls_d;
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign rls   = rls_q;

endmodule

// File: rtl/board_btn_debounce.sv
// Push-button conditioning for the board: N_BTN independent debounce channels
// giving clean levels and single-cycle press/release strobes.
module board_btn_debounce
    import board_io_pkg::*;
#(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .press(btn_press[i]),
            .rls  (btn_release[i])
        );
    end

endmodule

// File: tb/tb_board_btn_debounce.sv
// Randomised and directed bench for board_btn_debounce, checked per cycle
// against a run-length reference model through an expected-value queue.
module tb_board_btn_debounce;

    localparam int N_BTN = 3;
    localparam int DEB   = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_BTN-1:0] btn_raw = '0;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;

    board_btn_debounce #(
        .N_BTN          (N_BTN),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model + scoreboard ----------------
    // Record: {edge index[31:0], level[2:0], press[2:0], release[2:0]}
    logic [40:0]      exp_q[$];
    logic [N_BTN-1:0] m_level;
    int               m_run[N_BTN];
    bit               fresh;
    bit               pending_release;
    int               n_checks = 0;
    int               n_fail = 0;

    task automatic model_reset();
        m_level = '0;
        for (int c = 0; c < N_BTN; c++) m_run[c] = 0;
        fresh = 1'b1;
    endtask

    // A level change is accepted once DEB+1 consecutive samples disagree with
    // the current level; the effect shows two edges later (synchroniser).
    task automatic model_step(input logic [N_BTN-1:0] v, input int edge_idx);
        logic [N_BTN-1:0] prs;
        logic [N_BTN-1:0] rl;
        if (fresh) begin
            exp_q.push_back({32'(edge_idx), 9'b0});
            exp_q.push_back({32'(edge_idx + 1), 9'b0});
            fresh = 1'b0;
        end
        prs = '0;
        rl  = '0;
        for (int c = 0; c < N_BTN; c++) begin
            if (v[c] != m_level[c]) m_run[c]++;
            else m_run[c] = 0;
            if (m_run[c] == DEB + 1) begin
                if (v[c]) prs[c] = 1'b1;
                else rl[c] = 1'b1;
                m_level[c] = v[c];
                m_run[c]   = 0;
            end
        end
        exp_q.push_back({32'(edge_idx + 2), m_level, prs, rl});
    endtask

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    logic [40:0] rec;
    logic [8:0]  act_v;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && int'(exp_q[0][40:9]) < cyc) begin
            rec = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL stale_record: expectation for edge %0d never compared (now %0d)",
                     int'(rec[40:9]), cyc);
        end
        if (exp_q.size() > 0 && int'(exp_q[0][40:9]) == cyc) begin
            rec   = exp_q.pop_front();
            act_v = {btn_level, btn_press, btn_release};
            n_checks++;
            if (act_v !== rec[8:0]) begin
                n_fail++;
                $display("FAIL outputs@%0d: level/press/release got %b/%b/%b expected %b/%b/%b",
                         cyc, act_v[8:6], act_v[5:3], act_v[2:0], rec[8:6], rec[5:3], rec[2:0]);
            end
            n_checks++;
            if ((btn_press & btn_release) !== '0) begin
                n_fail++;
                $display("FAIL press_release_overlap@%0d: got %b expected 000",
                         cyc, btn_press & btn_release);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic [N_BTN-1:0] v);
        @(negedge clk);
        if (pending_release) begin
            rst_n = 1'b1;
            pending_release = 1'b0;
        end
        btn_raw = v;
        if (rst_n) model_step(v, cyc + 1);
    endtask

    task automatic reset_pulse(input logic [N_BTN-1:0] v, input int hold);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        check_eq("async_reset_level", 32'(btn_level), 32'd0);
        check_eq("async_reset_press", 32'(btn_press), 32'd0);
        check_eq("async_reset_release", 32'(btn_release), 32'd0);
        repeat (hold) drive(v);
        pending_release = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic [N_BTN-1:0] cur;
    logic [5:0]       bounce_pat;

    initial begin
        model_reset();
        pending_release = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("por_level", 32'(btn_level), 32'd0);
        check_eq("por_press", 32'(btn_press), 32'd0);
        check_eq("por_release", 32'(btn_release), 32'd0);
        pending_release = 1'b1;

        // Clean press on channel 0
        repeat (20) drive(3'b001);
        // Bounce on channel 1 while channel 0 stays held
        bounce_pat = 6'b110110;
        for (int i = 5; i >= 0; i--) drive({1'b0, bounce_pat[i], 1'b1});
        repeat (10) drive(3'b001);
        // Release channel 0
        repeat (12) drive(3'b000);
        // Long hold on channel 2
        repeat (100) drive(3'b100);
        repeat (12) drive(3'b000);
        // All channels together
        repeat (12) drive(3'b111);
        repeat (12) drive(3'b000);
        // Reset while channel 0 is qualifying, input kept high throughout
        repeat (5) drive(3'b001);
        reset_pulse(3'b001, 2);
        repeat (12) drive(3'b001);
        repeat (12) drive(3'b000);

        // Randomised bouncing on all channels with one reset in the middle
        cur = '0;
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < N_BTN; c++) begin
                if ($urandom_range(0, 5) == 0) cur[c] = ~cur[c];
            end
            drive(cur);
            if (i == 200) reset_pulse(cur, 2);
        end

        repeat (4) @(negedge clk);
        #1;
        check_eq("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
